adc_multi_chnl_model: RTL and testbench
=======================================

ADC_MULTI_CHNL_MODEL -- requirements
Module: adc_multi_chnl_model

Interface
REQ-001 Parameter NUM_CHNL, default 8, number of channels modelled (1..8).
REQ-002 Parameter DATA_W, default 12, conversion result width (8..12).
REQ-003 Parameter RAMP_STEP, default 1, increment applied per read in ramp mode.
REQ-004 clk  input  1  system clock; one clock; SPI pins are oversampled on clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SS_n  input  1  SPI slave select, active-low.
REQ-007 SCLK  input  1  SPI clock (mode 0).
REQ-008 MOSI  input  1  SPI command data from master.
REQ-009 MISO  output  1  SPI result data to master.
REQ-010 write  input  1  one-clk strobe: load wr_data into channel wr_chnl.
REQ-011 wr_chnl  input  3  channel index for write.
REQ-012 wr_data  input  DATA_W  value to load.
REQ-013 ramp_en  input  1  ramp mode enable.
REQ-014 frame_done  output  1  one-clk pulse on each valid 16-bit frame.
REQ-015 cur_chnl  output  3  channel selected for next result.
REQ-016 conv_cnt  output  16  count of valid frames.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 SS_n, SCLK, MOSI SHALL pass through a 2-flop synchronizer; edge detection uses synchronized values only.
REQ-019 The block SHALL hold NUM_CHNL value registers of DATA_W bits.
REQ-020 SS_n falling edge SHALL load a 16-bit tx shift register with {4'b0000, val[cur_chnl] left-justified in 12 bits, low 12-DATA_W bits zero} and clear the bit counter.
REQ-021 MISO SHALL equal tx[15] while SS_n low and 0 while SS_n high.
REQ-022 Each synchronized SCLK rising edge SHALL shift MOSI into a 16-bit rx register (MSB first) and increment the 5-bit bit counter.
REQ-023 Each synchronized SCLK falling edge SHALL shift tx left by one, filling 0.
REQ-024 SS_n rising edge with bit counter == 16 SHALL: set cur_chnl <= rx[13:11], pulse frame_done for one clk, increment conv_cnt (wraps 0xFFFF->0x0000).
REQ-025 SS_n rising edge with bit counter != 16 SHALL discard the frame: cur_chnl, conv_cnt, values unchanged, no frame_done, err set.
REQ-026 A valid frame with rx[13:11] >= NUM_CHNL SHALL set err and leave cur_chnl unchanged.
REQ-027 Result latency: value returned in frame N is the channel commanded in frame N-1 (pipelined, as ADC128S); first frame after reset returns channel 0.
REQ-028 In ramp mode, on each valid frame the channel just reported SHALL increment by RAMP_STEP, saturating at all-ones (no wrap).
REQ-029 write SHALL update val[wr_chnl] on the next clk; wr_chnl >= NUM_CHNL SHALL be ignored and set err.
REQ-030 write and ramp increment on the same channel in the same clk: write wins.
REQ-031 write during an active frame SHALL NOT alter the tx register already loaded.
REQ-032 err SHALL clear only on reset.
REQ-033 SCLK edges while SS_n high SHALL be ignored.

Reset
REQ-034 While rst_n low: all values 0, cur_chnl 0, conv_cnt 0, err 0, frame_done 0, MISO 0, shift registers and bit counter 0, synchronizer flops idle (SS_n=1, SCLK=0).
REQ-035 Reset asserted mid-frame SHALL abort the frame without frame_done or err; after release the block waits for a fresh SS_n fall.

Verification
REQ-036 write ch1=0xABC, frame cmd ch1, then frame cmd ch0 -> second frame MISO reads 0x0ABC, conv_cnt=2, cur_chnl=0.
REQ-037 DATA_W=10, write ch2=0x3FF, read ch2 -> MISO word 0x0FFC.
REQ-038 ramp_en=1, ch0=0xFFE, three consecutive reads of ch0 -> 0xFFE, 0xFFF, 0xFFF (saturated).
REQ-039 SS_n raised after 9 SCLK rises -> no frame_done, cur_chnl unchanged, err=1; next full frame valid.
REQ-040 NUM_CHNL=4, command ch6 -> err=1, cur_chnl unchanged; write to wr_chnl=5 ignored, err stays 1.
REQ-041 ramp_en=1, write ch0=0x100 in same clk as ch0 ramp increment -> ch0=0x100; rst_n low mid-frame -> all outputs return to reset values, no frame_done.

Source files
------------

// File: rtl/adc_multi_chnl_model.sv
// Behavioural multi-channel SPI ADC (ADC128S-style): 16-bit mode-0 frames, pipelined channel select, ramp/write value injection.
// Latency: result of frame N is the channel commanded in frame N-1; no backpressure, SPI pins oversampled on clk.
module adc_multi_chnl_model #(
  parameter int NUM_CHNL  = 8,
  parameter int DATA_W    = 12,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              write,
  input  logic [2:0]        wr_chnl,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ramp_en,
  output logic              frame_done,
  output logic [2:0]        cur_chnl,
  output logic [15:0]       conv_cnt,
  output logic              err
);

  logic ss_s1, ss_s2, ss_q;
  logic sclk_s1, sclk_s2, sclk_q;
  logic mosi_s1, mosi_s2;
  logic [1:0] sync_vld;
  logic armed, frame_act;

  logic [15:0] tx_sr, rx_sr;
  logic [4:0]  bit_cnt;
  logic [2:0]  rep_chnl;
  logic [DATA_W-1:0] vals [8];

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic frame_end, frame_ok, cmd_ok, wr_ok;
  logic [2:0] cmd_chnl;
  logic [DATA_W:0] ramp_sum;
  logic [DATA_W-1:0] ramp_val;
  logic unused_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      ss_q     <= 1'b1;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      ss_s1    <= SS_n;
      ss_s2    <= ss_s1;
      ss_q     <= ss_s2;
      sclk_s1  <= SCLK;
      sclk_s2  <= sclk_s1;
      sclk_q   <= sclk_s2;
      mosi_s1  <= MOSI;
      mosi_s2  <= mosi_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // Only a fall seen after SS_n was genuinely high starts a frame, so a
      // frame cut short by reset is never resumed.
      if (sync_vld[1] && ss_s2) armed <= 1'b1;
    end
  end

  assign ss_fall   = armed & ss_q & ~ss_s2;
  assign ss_rise   = ~ss_q & ss_s2;
  assign sclk_rise = frame_act & ~ss_s2 & sclk_s2 & ~sclk_q;
  assign sclk_fall = frame_act & ~ss_s2 & ~sclk_s2 & sclk_q;
  assign frame_end = frame_act & ss_rise;
  assign frame_ok  = frame_end & (bit_cnt == 5'd16);
  assign cmd_chnl  = rx_sr[13:11];
  assign cmd_ok    = 32'(cmd_chnl) < 32'(NUM_CHNL);
  assign wr_ok     = 32'(wr_chnl) < 32'(NUM_CHNL);
  assign unused_rx = ^{rx_sr[15:14], rx_sr[10:0]};

  assign ramp_sum  = {1'b0, vals[rep_chnl]} + (DATA_W+1)'(RAMP_STEP);
  assign ramp_val  = ramp_sum[DATA_W] ? {DATA_W{1'b1}} : ramp_sum[DATA_W-1:0];

  assign MISO = ~ss_s2 & tx_sr[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_act <= 1'b0;
      tx_sr     <= 16'h0000;
      rx_sr     <= 16'h0000;
      bit_cnt   <= 5'd0;
      rep_chnl  <= 3'd0;
    end else begin
      if (ss_fall) begin
        frame_act <= 1'b1;
        tx_sr     <= {4'b0000, 12'(vals[cur_chnl]) << (12 - DATA_W)};
        rx_sr     <= 16'h0000;
        bit_cnt   <= 5'd0;
        rep_chnl  <= cur_chnl;
      end else if (frame_end) begin
        frame_act <= 1'b0;
      end
      if (sclk_rise) begin
        rx_sr <= {rx_sr[14:0], mosi_s2};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (sclk_fall) tx_sr <= {tx_sr[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      cur_chnl   <= 3'd0;
      conv_cnt   <= 16'h0000;
      err        <= 1'b0;
    end else begin
      frame_done <= frame_ok;
      if (frame_ok) begin
        conv_cnt <= conv_cnt + 16'h0001;
        if (cmd_ok) cur_chnl <= cmd_chnl;
        else        err      <= 1'b1;
      end
      if (frame_end && !frame_ok) err <= 1'b1;
      if (write && !wr_ok)        err <= 1'b1;
    end
  end

  // Write is applied after the ramp so it wins on a same-clock collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) vals[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i < NUM_CHNL) begin
          if (frame_ok && ramp_en && rep_chnl == 3'(i)) vals[i] <= ramp_val;
          if (write && wr_chnl == 3'(i))                vals[i] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_multi_chnl_model.sv
// Directed bench for adc_multi_chnl_model: default, DATA_W=10 and NUM_CHNL=4 instances on shared SPI lines.
module tb_adc_multi_chnl_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ss_n;
  logic        sclk, mosi, ramp_en;
  logic [2:0]  wr;
  logic [2:0]  wr_chnl;
  logic [11:0] wr_data;
  logic [2:0]  miso, fd, errf;
  logic [2:0]  cur [3];
  logic [15:0] conv [3];
  int          fd_cnt [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  adc_multi_chnl_model u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .SCLK(sclk), .MOSI(mosi), .MISO(miso[0]),
    .write(wr[0]), .wr_chnl(wr_chnl), .wr_data(wr_data), .ramp_en(ramp_en),
    .frame_done(fd[0]), .cur_chnl(cur[0]), .conv_cnt(conv[0]), .err(errf[0])
  );

  adc_multi_chnl_model #(.DATA_W(10)) u_dw10 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .SCLK(sclk), .MOSI(mosi), .MISO(miso[1]),
    .write(wr[1]), .wr_chnl(wr_chnl), .wr_data(wr_data[9:0]), .ramp_en(ramp_en),
    .frame_done(fd[1]), .cur_chnl(cur[1]), .conv_cnt(conv[1]), .err(errf[1])
  );

  adc_multi_chnl_model #(.NUM_CHNL(4)) u_nc4 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .SCLK(sclk), .MOSI(mosi), .MISO(miso[2]),
    .write(wr[2]), .wr_chnl(wr_chnl), .wr_data(wr_data), .ramp_en(ramp_en),
    .frame_done(fd[2]), .cur_chnl(cur[2]), .conv_cnt(conv[2]), .err(errf[2])
  );

  initial for (int i = 0; i < 3; i++) fd_cnt[i] = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (fd[i] === 1'b1) fd_cnt[i] <= fd_cnt[i] + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_val(input int d, input logic [2:0] ch, input logic [11:0] dat);
    wr_chnl = ch;
    wr_data = dat;
    wr[d]   = 1'b1;
    wait_clk(1);
    wr[d]   = 1'b0;
    wait_clk(1);
  endtask

  // One SPI frame; optionally strobes a write on the clk where the frame is accepted.
  task automatic spi(input int d, input int nbits, input logic [2:0] ch, input bit wr_end,
                     input logic [11:0] wdat, output logic [15:0] rd);
    logic [15:0] cmd;
    cmd   = {2'b00, ch, 11'd0};
    rd    = 16'h0000;
    ss_n[d] = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[15-i];
      wait_clk(4);
      rd[15-i] = miso[d];
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    ss_n[d] = 1'b1;
    if (wr_end) begin
      wait_clk(2);
      wr_chnl = ch;
      wr_data = wdat;
      wr[d]   = 1'b1;
      wait_clk(1);
      wr[d]   = 1'b0;
    end
    wait_clk(6);
  endtask

  initial begin
    logic [15:0] rd;
    int base;

    rst_n = 1'b0; ss_n = 3'b111; sclk = 1'b0; mosi = 1'b0; wr = 3'b000;
    ramp_en = 1'b0; wr_chnl = 3'd0; wr_data = 12'h000;
    wait_clk(3);
    chk("rst_cur", 32'(cur[0]), 0);
    chk("rst_conv", 32'(conv[0]), 0);
    chk("rst_err", 32'(errf[0]), 0);
    chk("rst_fd", 32'(fd[0]), 0);
    chk("rst_miso", 32'(miso[0]), 0);
    rst_n = 1'b1;
    wait_clk(5);

    // Pipelined readback of a written value
    wr_val(0, 3'd1, 12'hABC);
    spi(0, 16, 3'd1, 1'b0, 12'h000, rd);
    chk("f1_miso", 32'(rd), 32'h0000);
    chk("f1_cur", 32'(cur[0]), 1);
    spi(0, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("f2_miso", 32'(rd), 32'h0ABC);
    chk("f2_conv", 32'(conv[0]), 2);
    chk("f2_cur", 32'(cur[0]), 0);
    chk("f2_fdcnt", 32'(fd_cnt[0]), 2);

    // Ramp saturation
    ramp_en = 1'b1;
    wr_val(0, 3'd0, 12'hFFE);
    spi(0, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("ramp1", 32'(rd), 32'h0FFE);
    spi(0, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("ramp2", 32'(rd), 32'h0FFF);
    spi(0, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("ramp3", 32'(rd), 32'h0FFF);
    ramp_en = 1'b0;
    chk("ramp_conv", 32'(conv[0]), 5);
    chk("ramp_err", 32'(errf[0]), 0);

    // Short frame is discarded
    base = fd_cnt[0];
    spi(0, 9, 3'd3, 1'b0, 12'h000, rd);
    chk("short_fd", 32'(fd_cnt[0] - base), 0);
    chk("short_cur", 32'(cur[0]), 0);
    chk("short_conv", 32'(conv[0]), 5);
    chk("short_err", 32'(errf[0]), 1);
    spi(0, 16, 3'd2, 1'b0, 12'h000, rd);
    chk("after_short_miso", 32'(rd), 32'h0FFF);
    chk("after_short_cur", 32'(cur[0]), 2);
    chk("after_short_conv", 32'(conv[0]), 6);
    chk("after_short_fd", 32'(fd_cnt[0] - base), 1);

    // Write beats ramp on the same clk
    wr_val(0, 3'd0, 12'h050);
    spi(0, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("ww_pre", 32'(rd), 32'h0000);
    ramp_en = 1'b1;
    spi(0, 16, 3'd0, 1'b1, 12'h100, rd);
    chk("ww_rep", 32'(rd), 32'h0050);
    ramp_en = 1'b0;
    spi(0, 16, 3'd3, 1'b0, 12'h000, rd);
    chk("ww_val", 32'(rd), 32'h0100);
    chk("ww_conv", 32'(conv[0]), 9);
    chk("ww_cur", 32'(cur[0]), 3);

    // DATA_W=10 left-justification
    wr_val(1, 3'd2, 12'h3FF);
    spi(1, 16, 3'd2, 1'b0, 12'h000, rd);
    chk("dw10_first", 32'(rd), 32'h0000);
    spi(1, 16, 3'd0, 1'b0, 12'h000, rd);
    chk("dw10_word", 32'(rd), 32'h0FFC);

    // NUM_CHNL=4 out-of-range command and write
    chk("nc4_err0", 32'(errf[2]), 0);
    spi(2, 16, 3'd6, 1'b0, 12'h000, rd);
    chk("nc4_err", 32'(errf[2]), 1);
    chk("nc4_cur", 32'(cur[2]), 0);
    chk("nc4_conv", 32'(conv[2]), 1);
    wr_val(2, 3'd5, 12'h123);
    chk("nc4_wr_err", 32'(errf[2]), 1);

    // Reset in the middle of a frame
    base = fd_cnt[0];
    ss_n[0] = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    wait_clk(2);
    chk("mid_rst_cur", 32'(cur[0]), 0);
    chk("mid_rst_conv", 32'(conv[0]), 0);
    chk("mid_rst_err", 32'(errf[0]), 0);
    chk("mid_rst_miso", 32'(miso[0]), 0);
    chk("mid_rst_fd", 32'(fd[0]), 0);
    rst_n = 1'b1;
    wait_clk(10);
    ss_n[0] = 1'b1;
    wait_clk(10);
    chk("post_rst_fd", 32'(fd_cnt[0] - base), 0);
    chk("post_rst_err", 32'(errf[0]), 0);
    chk("post_rst_conv", 32'(conv[0]), 0);
    spi(0, 16, 3'd1, 1'b0, 12'h000, rd);
    chk("post_rst_miso", 32'(rd), 32'h0000);
    chk("post_rst_cur", 32'(cur[0]), 1);
    chk("post_rst_conv1", 32'(conv[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
